regfile_dump: RTL and testbench
===============================

# regfile_dump

Debug/verification reader for the 32 x 32-bit integer register file of the multicycle RV32 core. On a `start` pulse it walks every register address 0..NUM_REGS-1 through one combinational read port of the register file. It captures each value and streams it out as an (address, data) beat on a valid/ready interface, then pulses `done`. It is the reading end of the register file: the core writes, this block reads. It drives only a read address and never writes.

## Interface
Parameters:
- `NUM_REGS`, 32: registers scanned, addresses 0..NUM_REGS-1.
- `ADDR_W`, 5: register address width; must satisfy 2^ADDR_W >= NUM_REGS.
- `DATA_W`, 32: register data width.

Ports:
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request a dump. Sampled only in IDLE.
- `rd_addr` output ADDR_W: read address to the register file read port.
- `rd_data` input DATA_W: combinational read data for `rd_addr`. x0 returns 0.
- `m_valid` output 1: output beat valid.
- `m_ready` input 1: downstream accepts the beat.
- `m_addr` output ADDR_W: register index of the current beat.
- `m_data` output DATA_W: register value of the current beat.
- `m_last` output 1: current beat is index NUM_REGS-1.
- `busy` output 1: dump in progress, i.e. state != IDLE.
- `done` output 1: single-cycle pulse after the last beat is accepted.

## Operation
- States: IDLE, READ, SEND, DONE. Internal counter `idx` (ADDR_W bits).
- IDLE: `rd_addr`=0, `m_valid`=0. If `start`=1, set `idx`<=0 and go to READ. Otherwise stay.
- READ: `rd_addr`=`idx`.
  - At the edge: `m_data`<=`rd_data`, `m_addr`<=`idx`, `m_last`<=(`idx`==NUM_REGS-1), `m_valid`<=1.
  - Go to SEND.
- SEND: hold `m_valid`, `m_addr`, `m_data` and `m_last` stable until `m_valid`&&`m_ready` at an edge. At that edge, `m_valid`<=0, then:
  - if `idx`==NUM_REGS-1, go to DONE;
  - otherwise `idx`<=`idx`+1 and go to READ.
- DONE: `done`=1 for exactly this cycle, then go to IDLE.
- `start` outside IDLE is ignored. It is neither queued nor restarts the scan.
- `idx` never wraps. The scan ends at NUM_REGS-1, and the increment is never taken there.
- Each register is sampled in its READ cycle. Writes to the register file after that cycle are not reflected. No cross-register snapshot coherency is provided.
- `m_valid` is never withdrawn before acceptance, except by reset.
- `m_ready` is ignored while `m_valid`=0.

## Timing
- Reset (asynchronous assert, any state): state=IDLE, `idx`=0, `rd_addr`=0, `m_valid`=0, `m_addr`=0, `m_data`=0, `m_last`=0, `busy`=0, `done`=0. Reset mid-dump aborts it immediately, and no `done` is produced.
- Start latency:
  - `start` is sampled at edge E0; cycle 1 is READ with `rd_addr`=0.
  - The first beat is valid in cycle 2.
- Per register: minimum 2 cycles (READ + SEND). Each cycle `m_ready` stays low while valid adds one cycle.
- With `m_ready`=1 throughout:
  - beat k is valid in cycle 2+2k;
  - the last beat (k=31) is valid in cycle 64;
  - `done`=1 in cycle 65;
  - the block is back in IDLE (`busy`=0) in cycle 66.
- `busy` rises in cycle 1 and stays high through the DONE cycle.
- A `start` in the first IDLE cycle after DONE begins a new dump. There is no dead cycle beyond DONE.

## Test plan
- Full dump, no backpressure: preload x1..x31 = 0xA5A50000+i, hold `m_ready`=1, pulse `start` → 32 beats with `m_addr`=0..31, `m_data`(0)=0 and `m_data`(i)=0xA5A50000+i, `m_last` only on beat 31, `done` one cycle in cycle 65.
- Backpressure: same preload, `m_ready` random at 50% → identical beat sequence, no beat lost or duplicated, and `m_addr`, `m_data`, `m_last` stable while `m_valid`&&!`m_ready`.
- Start while busy: pulse `start` again during beat 5 → ignored, and exactly 32 beats followed by one `done`.
- Reset mid-dump: assert `rst_n`=0 during beat 10 → all outputs 0 asynchronously, and no `done`. A subsequent `start` → a full 32-beat dump from index 0.
- Live write: core writes x7=0xDEADBEEF in the cycle after x7's READ cycle → beat 7 carries the old value. The same write before x7's READ cycle → beat 7 carries 0xDEADBEEF.
- Back-to-back dumps: `start` in the first IDLE cycle after `done` → a second complete dump starts, with `busy` high in the cycle after that `start`.

Source files
------------

// File: rtl/regfile_dump.sv
`timescale 1ns/1ps
// Debug reader for the integer register file: walks addresses 0..NUM_REGS-1 through
// one combinational read port and streams (address, data) beats on a valid/ready port.
module regfile_dump #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            state;
    logic [ADDR_W-1:0] idx;

    // rd_addr is kept as a register that tracks idx during a scan and parks at 0 otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            rd_addr <= '0;
            m_valid <= 1'b0;
            m_addr  <= '0;
            m_data  <= '0;
            m_last  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx     <= '0;
                        rd_addr <= '0;
                        busy    <= 1'b1;
                        state   <= READ;
                    end
                end
                READ: begin
                    m_data  <= rd_data;
                    m_addr  <= idx;
                    m_last  <= (idx == LAST_IDX);
                    m_valid <= 1'b1;
                    state   <= SEND;
                end
                SEND: begin
                    if (m_valid && m_ready) begin
                        m_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            rd_addr <= '0;
                            done    <= 1'b1;
                            state   <= DONE;
                        end else begin
                            idx     <= idx + ADDR_W'(1);
                            rd_addr <= idx + ADDR_W'(1);
                            state   <= READ;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
`timescale 1ns/1ps
// Directed-plus-random bench for regfile_dump with a register-array model of the core
// side and a rule-based expectation of the beat stream.
module tb_regfile_dump;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        m_valid;
    logic        m_ready;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        m_last;
    logic        busy;
    logic        done;

    logic [31:0] regs [32];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    assign rd_data = (rd_addr == 5'd0) ? 32'd0 : regs[rd_addr];

    regfile_dump #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_addr(m_addr), .m_data(m_data), .m_last(m_last),
        .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " rd_addr"}, 32'(rd_addr), 32'd0);
        check({tag, " m_valid"}, 32'(m_valid), 32'd0);
        check({tag, " m_addr"},  32'(m_addr),  32'd0);
        check({tag, " m_data"},  m_data,       32'd0);
        check({tag, " m_last"},  32'(m_last),  32'd0);
        check({tag, " busy"},    32'(busy),    32'd0);
        check({tag, " done"},    32'(done),    32'd0);
    endtask

    // Caller has set start=1 in an IDLE cycle; this task performs edge E0 and the scan.
    task automatic run_dump(input string tag, input int ready_pct, input int again_beat,
                            input int reset_beat, input int write_cycle);
        logic [31:0] exp_data [32];
        int cyc, beat, seen_beat;
        bit done_seen, accepted;

        for (int i = 0; i < 32; i++) exp_data[i] = (i == 0) ? 32'd0 : regs[i];
        // register k is read in cycle 1+2k when the sink never stalls
        if (write_cycle > 0 && write_cycle <= 1 + 2 * 7) exp_data[7] = 32'hDEADBEEF;

        step();
        start = 1'b0;
        cyc = 1;
        check({tag, " busy c1"}, 32'(busy), 32'd1);
        check({tag, " rd_addr c1"}, 32'(rd_addr), 32'd0);
        check({tag, " m_valid c1"}, 32'(m_valid), 32'd0);

        beat = 0;
        seen_beat = -1;
        done_seen = 0;
        while (!done_seen && cyc < 1000) begin
            if (write_cycle == cyc) regs[7] = 32'hDEADBEEF;
            if (reset_beat >= 0 && beat == reset_beat && m_valid) begin
                #2 rst_n = 1'b0;
                #1 check_all_zero({tag, " async rst"});
                #1 rst_n = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    step();
                    check({tag, " no done after rst"}, 32'(done), 32'd0);
                end
                return;
            end
            if (m_valid) begin
                check({tag, " m_addr"}, 32'(m_addr), beat);
                check({tag, " m_data"}, m_data, exp_data[beat]);
                check({tag, " m_last"}, 32'(m_last), 32'(beat == 31));
                if (ready_pct == 100 && seen_beat != beat)
                    check({tag, " beat cycle"}, cyc, 2 + 2 * beat);
                seen_beat = beat;
            end
            if (done) begin
                check({tag, " beats before done"}, beat, 32);
                if (ready_pct == 100) check({tag, " done cycle"}, cyc, 65);
                done_seen = 1;
            end else begin
                check({tag, " busy during scan"}, 32'(busy), 32'd1);
                start   = (again_beat == beat) && m_valid;
                m_ready = (ready_pct == 100) ? 1'b1 : 1'($urandom_range(0, 1));
                accepted = m_valid && m_ready;
                step();
                cyc++;
                if (accepted) beat++;
            end
        end
        start = 1'b0;
        if (!done_seen) begin
            check({tag, " timeout waiting done"}, 32'(done_seen), 32'd1);
            return;
        end
        step();
        cyc++;
        if (ready_pct == 100) check({tag, " idle cycle"}, cyc, 66);
        check({tag, " busy after done"}, 32'(busy), 32'd0);
        check({tag, " done one cycle"}, 32'(done), 32'd0);
        check({tag, " rd_addr idle"}, 32'(rd_addr), 32'd0);
        check({tag, " m_valid idle"}, 32'(m_valid), 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 32'hA5A50000 + i;
        #3 check_all_zero("reset");
        #20 rst_n = 1'b1;
        step();
        check_all_zero("after reset");

        start = 1'b1;
        run_dump("full", 100, -1, -1, 0);

        step();
        start = 1'b1;
        run_dump("bp", 50, -1, -1, 0);

        step();
        start = 1'b1;
        run_dump("start busy", 100, 5, -1, 0);

        step();
        start = 1'b1;
        run_dump("rst mid", 100, -1, 10, 0);
        check_all_zero("idle after abort");
        start = 1'b1;
        run_dump("after rst", 100, -1, -1, 0);

        step();
        start = 1'b1;
        run_dump("write late", 100, -1, -1, 16);
        regs[7] = 32'hA5A50007;
        step();
        start = 1'b1;
        run_dump("write early", 100, -1, -1, 14);
        regs[7] = 32'hA5A50007;

        step();
        start = 1'b1;
        run_dump("b2b first", 100, -1, -1, 0);
        start = 1'b1;
        run_dump("b2b second", 50, -1, -1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
